// File: rtl/seq_pattern_gen_if.sv
// Handshake/data bundle between a pattern-generator controller and seq_pattern_gen.
// master drives the frame request; slave returns the serial stream and status.
interface seq_pattern_gen_if #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 4
);
    // start is a level sampled only while the generator is idle; there is no ready,
    // so a start seen while busy is dropped rather than held or queued.
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] rep_cnt;
    logic             seq_out;
    logic             seq_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, pattern, rep_cnt,
        input  seq_out, seq_valid, busy, done
    );

    modport slave (
        input  start, abort, pattern, rep_cnt,
        output seq_out, seq_valid, busy, done
    );
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, repeated, with optional idle gaps.
// Define SEQ_GEN_PARITY_EN to append an even-parity bit after every repetition.
module seq_pattern_gen #(
    parameter int PAT_W   = 3,
    parameter int CNT_W   = 4,
    parameter int GAP_CYC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_pattern_gen_if.slave   bus,
    output logic [1:0]         state_dbg
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

`ifdef SEQ_GEN_PARITY_EN
    localparam int REP_LEN = PAT_W + 1;
`else
    localparam int REP_LEN = PAT_W;
`endif
    localparam int BIT_W = $clog2(REP_LEN);
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(REP_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] REP_ONE  = CNT_W'(1);

    logic [1:0]       state;
    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] shreg;
    logic [BIT_W-1:0] bit_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [CNT_W-1:0] rep_q;
    logic             seq_out_q;
    logic             seq_valid_q;
    logic             busy_q;
    logic             done_q;

    assign bus.seq_out   = seq_out_q;
    assign bus.seq_valid = seq_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign state_dbg     = state;

    // Outputs are computed together with the next state so each is a plain flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pat_q       <= '0;
            shreg       <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            rep_q       <= '0;
            seq_out_q   <= 1'b0;
            seq_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (state != S_IDLE && bus.abort) begin
            state       <= S_IDLE;
            seq_out_q   <= 1'b0;
            seq_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state       <= S_SEND;
                        pat_q       <= bus.pattern;
                        shreg       <= bus.pattern;
                        bit_cnt     <= '0;
                        rep_q       <= (bus.rep_cnt == '0) ? REP_ONE : bus.rep_cnt;
                        seq_out_q   <= bus.pattern[PAT_W-1];
                        seq_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (bit_cnt != BIT_LAST) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        shreg   <= {shreg[PAT_W-2:0], 1'b0};
`ifdef SEQ_GEN_PARITY_EN
                        if (bit_cnt == BIT_W'(PAT_W - 1)) seq_out_q <= ^pat_q;
                        else                              seq_out_q <= shreg[PAT_W-2];
`else
                        seq_out_q <= shreg[PAT_W-2];
`endif
                    end else if (rep_q > REP_ONE) begin
                        rep_q <= rep_q - 1'b1;
                        if (GAP_CYC > 0) begin
                            state       <= S_GAP;
                            gap_cnt     <= '0;
                            seq_out_q   <= 1'b0;
                            seq_valid_q <= 1'b0;
                        end else begin
                            shreg     <= pat_q;
                            bit_cnt   <= '0;
                            seq_out_q <= pat_q[PAT_W-1];
                        end
                    end else begin
                        state       <= S_DONE;
                        seq_out_q   <= 1'b0;
                        seq_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state       <= S_SEND;
                        shreg       <= pat_q;
                        bit_cnt     <= '0;
                        seq_out_q   <= pat_q[PAT_W-1];
                        seq_valid_q <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: begin
                    state       <= S_IDLE;
                    seq_out_q   <= 1'b0;
                    seq_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: a back-to-back instance and a 2-cycle-gap instance share stimulus,
// each compared cycle by cycle against an expected {busy,done,valid,out} stream built from the frame rules.
module tb_seq_pattern_gen;
    localparam int PAT_W = 3;
    localparam int CNT_W = 4;
    localparam int GAP1  = 2;
    localparam int LIMIT = 200;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             start   = 1'b0;
    logic             abort   = 1'b0;
    logic [PAT_W-1:0] pattern = '0;
    logic [CNT_W-1:0] rep_cnt = '0;
    logic [1:0]       st0, st1;

    seq_pattern_gen_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) if0 ();
    seq_pattern_gen_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) if1 ();

    assign if0.start = start;   assign if1.start = start;
    assign if0.abort = abort;   assign if1.abort = abort;
    assign if0.pattern = pattern; assign if1.pattern = pattern;
    assign if0.rep_cnt = rep_cnt; assign if1.rep_cnt = rep_cnt;

    seq_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_CYC(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave), .state_dbg(st0));
    seq_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_CYC(GAP1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave), .state_dbg(st1));

    wire [3:0] obs0 = {if0.busy, if0.done, if0.seq_valid, if0.seq_out};
    wire [3:0] obs1 = {if1.busy, if1.done, if1.seq_valid, if1.seq_out};

    // scoreboard
    logic [3:0] exp_q0[$];
    logic [3:0] exp_q1[$];
    logic [3:0] last0 = '0, last1 = '0;
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s t=%0t got=%b exp=%b", tag, $time, got, exp);
    endtask

    // Expected per-cycle stream from acceptance edge onward: R repetitions of the
    // pattern bits (plus parity), gap idles between repetitions, then one done cycle.
    task automatic build(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] rc, input int gap, input int sel);
        int r_n;
        logic [3:0] q[$];
        r_n = (rc == 0) ? 1 : int'(rc);
        for (int r = 0; r < r_n; r++) begin
            for (int b = PAT_W - 1; b >= 0; b--) q.push_back({3'b101, pat[b]});
`ifdef SEQ_GEN_PARITY_EN
            q.push_back({3'b101, ^pat});
`endif
            if (r < r_n - 1)
                for (int g = 0; g < gap; g++) q.push_back(4'b1000);
        end
        q.push_back(4'b1100);
        foreach (q[i]) begin
            if (sel == 0) exp_q0.push_back(q[i]);
            else          exp_q1.push_back(q[i]);
        end
    endtask

    task automatic step();
        logic [3:0] e0, e1;
        @(posedge clk);
        #1;
        e0 = (exp_q0.size() != 0) ? exp_q0.pop_front() : 4'b0000;
        e1 = (exp_q1.size() != 0) ? exp_q1.pop_front() : 4'b0000;
        check("gap0", obs0, e0);
        check("gap2", obs1, e1);
        last0 = e0;
        last1 = e1;
    endtask

    // driver: start_at re-pulses start while both are busy; abort_at cancels at that cycle
    task automatic frame(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] rc,
                         input int abort_at, input int start_at);
        int k;
        build(pat, rc, 0, 0);
        build(pat, rc, GAP1, 1);
        pattern = pat;
        rep_cnt = rc;
        start   = 1'b1;
        step();
        start   = 1'b0;
        pattern = PAT_W'($urandom);
        rep_cnt = CNT_W'($urandom);
        k = 1;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && k < LIMIT) begin
            if (k == start_at && last0[3] && last1[3]) start = 1'b1;
            if (k == abort_at) begin
                abort = 1'b1;
                exp_q0.delete();
                exp_q1.delete();
            end
            step();
            start = 1'b0;
            abort = 1'b0;
            k++;
        end
        check("timeout", 4'(exp_q0.size() + exp_q1.size() != 0), 4'd0);
        step();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst0", obs0, 4'b0000);
        check("rst2", obs1, 4'b0000);
        rst_n = 1'b1;
        step();

        frame(3'b101, 4'd1, -1, -1);
        frame(3'b101, 4'd3, -1, -1);
        frame(3'b110, 4'd2, -1, -1);
        frame(3'b011, 4'd0, -1, -1);
        frame(3'b101, 4'd3, 5, 2);
        frame(3'b101, 4'd1, -1, -1);

        // asynchronous reset while dut1 sits in its gap
        build(3'b110, 4'd2, 0, 0);
        build(3'b110, 4'd2, GAP1, 1);
        pattern = 3'b110;
        rep_cnt = 4'd2;
        start   = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        check("in_gap", last1, 4'b1000);
        #2 rst_n = 1'b0;
        #1;
        check("arst0", obs0, 4'b0000);
        check("arst2", obs1, 4'b0000);
        exp_q0.delete();
        exp_q1.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        frame(3'b101, 4'd1, -1, -1);

        for (int i = 0; i < 25; i++) begin
            frame(PAT_W'($urandom), CNT_W'($urandom_range(0, 4)),
                  ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 14)) : -1,
                  int'($urandom_range(1, 10)));
            repeat ($urandom_range(0, 2)) step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
